// File: rtl/seq_scan_pkg.sv
// Shared definitions for the serial scan controller and its pattern detector.
package seq_scan_pkg;

  localparam int unsigned PAT_W = 4;
  localparam logic [PAT_W-1:0] RST_PATTERN = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH,
    REPORT
  } state_t;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word-in / result-out handshakes plus configuration and status of the scan controller.
interface seq_scan_ctrl_if #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 8
);
  import seq_scan_pkg::*;

  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              res_valid;
  logic              res_ready;
  logic [CNT_W-1:0]  res_count;
  logic              match;
  logic              busy;

  modport master (
    output cfg_we, cfg_pattern, in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_count, match, busy
  );

  modport slave (
    input  cfg_we, cfg_pattern, in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_count, match, busy
  );

endinterface

// File: rtl/seq_pat_detect.sv
// Programmable overlapping Moore detector: flags when the last PAT_W bits equal the pattern.
module seq_pat_detect #(
  parameter int unsigned PAT_W = seq_scan_pkg::PAT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_PRE  = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  next_hist;

  assign next_hist = {hist[PAT_W-2:0], bit_in};

  // History/fill tracking; match registers the comparison including the incoming bit.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= 1'b0;
      if (bit_valid) begin
        hist <= next_hist;
        if (fill != FILL_FULL) begin
          fill <= fill + 1'b1;
        end
        match <= (fill >= FILL_PRE) && (next_hist == pattern);
      end
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts words, shifts them MSB-first into the pattern detector and reports per-frame match counts.
module seq_scan_ctrl #(
  parameter int unsigned      WORD_W      = 8,
  parameter int unsigned      CNT_W       = 8,
  parameter int unsigned      PAT_W       = seq_scan_pkg::PAT_W,
  parameter logic [PAT_W-1:0] RST_PATTERN = seq_scan_pkg::RST_PATTERN
) (
  input logic           clock,
  input logic           reset,
  seq_scan_ctrl_if.slave bus
);
  import seq_scan_pkg::*;

  localparam int unsigned BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

  state_t            state;
  logic [PAT_W-1:0]  pattern;
  logic [WORD_W-1:0] shreg;
  logic [BC_W-1:0]   bitcnt;
  logic              last_flag;
  logic              in_ready_q;
  logic              busy_q;
  logic              res_valid_q;
  logic [CNT_W-1:0]  count;
  logic              det_match;
  logic              clr;

  // Result handshake empties the frame: counter and detector history restart together.
  assign clr = (state == REPORT) && bus.res_ready;

  seq_pat_detect #(
    .PAT_W (PAT_W)
  ) u_det (
    .clock     (clock),
    .reset     (reset),
    .clr       (clr),
    .bit_valid (state == SHIFT),
    .bit_in    (shreg[WORD_W-1]),
    .pattern   (pattern),
    .match     (det_match)
  );

  // Controller FSM with shifter, pattern register and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pattern     <= RST_PATTERN;
      shreg       <= '0;
      bitcnt      <= '0;
      last_flag   <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cfg_we) begin
            pattern <= bus.cfg_pattern;
          end
          if (bus.in_valid) begin
            shreg      <= bus.in_data;
            last_flag  <= bus.in_last;
            bitcnt     <= '0;
            state      <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          shreg  <= {shreg[WORD_W-2:0], 1'b0};
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == LAST_BIT) begin
            if (last_flag) begin
              state <= FLUSH;
            end else begin
              state      <= IDLE;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state       <= REPORT;
          res_valid_q <= 1'b1;
        end
        REPORT: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating frame match counter; counts in any state so a last-bit match landing in IDLE/FLUSH is kept.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (det_match && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_count = count;
  assign bus.match     = det_match;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed scoreboard bench for seq_scan_ctrl.
module tb_seq_scan_ctrl;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  seq_scan_ctrl_if #(.WORD_W(8), .CNT_W(8)) bus ();

  seq_scan_ctrl #(
    .WORD_W (8),
    .CNT_W  (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned exp_q[$];
  logic [15:0] mask;
  int unsigned waited;
  logic        seen;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers a word once in_ready is seen; returns in cycle 1 of the word.
  task automatic send_word(input logic [7:0] d, input logic l);
    int unsigned n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    chk("in_ready_wait", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    tick;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  // Samples match during cycles 1..9 of a word; m[c] = match in cycle c. Ends in cycle 9.
  task automatic shift_word(output logic [15:0] m);
    m = '0;
    for (int c = 1; c <= 9; c++) begin
      m[c] = bus.match;
      if (c < 9) tick;
    end
  endtask

  // Waits (bounded) for a result, checks it against the scoreboard and completes the handshake.
  task automatic get_result(output int unsigned w);
    int unsigned e;
    w = 0;
    while (bus.res_valid !== 1'b1 && w < 40) begin
      tick;
      w++;
    end
    chk("res_valid_arrive", bus.res_valid, 1);
    if (bus.res_valid === 1'b1) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("res_count", bus.res_count, e);
      end else begin
        fails++;
        $display("FAIL sb_underflow: observed result %0d required none", bus.res_count);
      end
      tick;
      chk("post_hs_in_ready", bus.in_ready, 1);
      chk("post_hs_res_valid", bus.res_valid, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b1;
    bus.cfg_we      = 1'b0;
    bus.cfg_pattern = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_last     = 1'b0;
    bus.res_ready   = 1'b1;
    repeat (3) tick;

    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_match", bus.match, 0);
    chk("rst_count", bus.res_count, 0);
    reset = 1'b0;
    tick;

    // Single word, reset pattern 1001
    exp_q.push_back(2);
    send_word(8'b10010010, 1'b1);
    chk("t1_busy", bus.busy, 1);
    shift_word(mask);
    chk("t1_match_cycles", mask, 16'h0120);
    chk("t1_flush_busy", bus.busy, 1);
    chk("t1_flush_valid", bus.res_valid, 0);
    get_result(waited);
    chk("t1_latency", waited, 1);
    chk("t1_idle_busy", bus.busy, 0);

    // Pattern spanning a word boundary
    exp_q.push_back(1);
    send_word(8'b00000010, 1'b0);
    shift_word(mask);
    chk("x_w0_mask", mask, 0);
    chk("x_w0_idle_ready", bus.in_ready, 1);
    chk("x_w0_idle_busy", bus.busy, 0);
    send_word(8'b01000000, 1'b1);
    shift_word(mask);
    chk("x_w1_mask", mask, 16'h0008);
    get_result(waited);
    chk("x_latency", waited, 1);

    // Load 1111 in IDLE
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = 4'b1111;
    tick;
    bus.cfg_we      = 1'b0;
    exp_q.push_back(5);
    send_word(8'hFF, 1'b1);
    shift_word(mask);
    chk("ff_mask", mask, 16'h03E0);
    get_result(waited);

    // cfg_we while busy must be ignored
    exp_q.push_back(5);
    send_word(8'hFF, 1'b1);
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = 4'b0000;
    shift_word(mask);
    bus.cfg_we      = 1'b0;
    chk("cfg_busy_mask", mask, 16'h03E0);
    get_result(waited);

    // cfg_we with in_valid: new pattern applies to that word
    exp_q.push_back(2);
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = 4'b1001;
    send_word(8'b10010010, 1'b1);
    bus.cfg_we      = 1'b0;
    shift_word(mask);
    chk("cfg_same_mask", mask, 16'h0120);
    get_result(waited);

    // Result backpressure
    exp_q.push_back(2);
    bus.res_ready = 1'b0;
    send_word(8'b10010010, 1'b1);
    shift_word(mask);
    tick;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      chk("bp_res_valid", bus.res_valid, 1);
      chk("bp_res_count", bus.res_count, 2);
      chk("bp_in_ready", bus.in_ready, 0);
      tick;
    end
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b1;
    get_result(waited);
    chk("bp_wait", waited, 0);

    // Saturation: 52 words of FF with pattern 1111
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = 4'b1111;
    tick;
    bus.cfg_we      = 1'b0;
    exp_q.push_back(255);
    for (int w = 0; w < 52; w++) begin
      send_word(8'hFF, (w == 51) ? 1'b1 : 1'b0);
      shift_word(mask);
    end
    get_result(waited);

    // Reset mid-SHIFT discards the frame
    send_word(8'hFF, 1'b1);
    repeat (4) tick;
    chk("mid_busy", bus.busy, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_match", bus.match, 0);
    chk("mid_rst_count", bus.res_count, 0);
    seen = 1'b0;
    repeat (12) begin
      tick;
      if (bus.res_valid !== 1'b0) seen = 1'b1;
    end
    chk("mid_rst_no_result", seen, 0);

    // Pattern back at 1001 after reset
    exp_q.push_back(2);
    send_word(8'b10010010, 1'b1);
    shift_word(mask);
    chk("post_rst_mask", mask, 16'h0120);
    get_result(waited);

    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
